// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter for asynchronous event requests.
// Each request line is synchronised, rising-edge detected and latched as pending;
// pending requests are granted one at a time over a valid/ready handshake.
module sync_req_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned NO_STAGES = 2,
    parameter int unsigned ID_W      = $clog2(N_REQ)
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic [N_REQ-1:0]  i_async_req,
    input  logic              i_grant_ready,
    input  logic              i_clr_ovf,
    output logic              o_grant_valid,
    output logic [ID_W-1:0]   o_grant_id,
    output logic [N_REQ-1:0]  o_pending,
    output logic [N_REQ-1:0]  o_overflow
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [ID_W-1:0] LastId = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]   NReqW  = (ID_W + 1)'(N_REQ);

    logic [N_REQ-1:0] sync_q [NO_STAGES];
    logic [N_REQ-1:0] sync_d [NO_STAGES];
    logic [N_REQ-1:0] prev_q, prev_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] ovf_q, ovf_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    state_e           state_q, state_d;

    logic [N_REQ-1:0] synced;
    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] consume;
    logic             handshake;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic [ID_W:0]    cand_sum;
    logic [ID_W-1:0]  cand;

    // Plain flop chain per bit, then rising-edge detect on the last stage.
    always_comb begin
        sync_d[0] = i_async_req;
        for (int unsigned s = 1; s < NO_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        synced = sync_q[NO_STAGES-1];
        prev_d = synced;
        rise   = synced & ~prev_q;
    end

    // Round-robin pick: first pending index at or after ptr, wrapping around.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_sum = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (cand_sum >= NReqW) begin
                cand_sum = cand_sum - NReqW;
            end
            cand = cand_sum[ID_W-1:0];
            if (!found && pending_q[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Grant FSM: register a winner from IDLE, hold it until the handshake.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        handshake  = 1'b0;
        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_id_d = winner;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (i_grant_ready) begin
                    handshake = 1'b1;
                    ptr_d     = (grant_id_q == LastId) ? '0 : grant_id_q + ID_W'(1);
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pending/overflow update; a rise coinciding with its own consume re-queues cleanly.
    always_comb begin
        consume = '0;
        if (handshake) begin
            consume[grant_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~consume) | rise;
        ovf_d     = (i_clr_ovf ? '0 : ovf_q) | (rise & pending_q & ~consume);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            for (int unsigned s = 0; s < NO_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q     <= '0;
            pending_q  <= '0;
            ovf_q      <= '0;
            ptr_q      <= '0;
            grant_id_q <= '0;
            state_q    <= StIdle;
        end else begin
            for (int unsigned s = 0; s < NO_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            state_q    <= state_d;
        end
    end

    assign o_grant_valid = (state_q == StGrant);
    assign o_grant_id    = grant_id_q;
    assign o_pending     = pending_q;
    assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Bench for sync_req_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a delay-line + round-robin reference model.
module tb_sync_req_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned NST  = 2;
    localparam int unsigned IDW  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic            ready;
    logic            clr;
    logic            valid;
    logic [IDW-1:0]  id;
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic [NREQ-1:0] hist [$];
    bit              m_busy;
    logic [IDW-1:0]  m_id;
    logic [IDW-1:0]  m_ptr;
    logic [NREQ-1:0] m_pend;
    logic [NREQ-1:0] m_ovf;

    sync_req_arbiter #(
        .N_REQ     (NREQ),
        .NO_STAGES (NST)
    ) dut (
        .i_clk         (clk),
        .i_arst_n      (rst_n),
        .i_async_req   (req),
        .i_grant_ready (ready),
        .i_clr_ovf     (clr),
        .o_grant_valid (valid),
        .o_grant_id    (id),
        .o_pending     (pend),
        .o_overflow    (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Lowest pending index >= ptr, else lowest index below ptr.
    function automatic int rr_pick(input logic [NREQ-1:0] p, input int ptr);
        for (int j = ptr; j < int'(NREQ); j++) if (p[j]) return j;
        for (int j = 0; j < ptr; j++) if (p[j]) return j;
        return 0;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= int'(NST); i++) hist.push_front('0);
        m_busy = 1'b0;
        m_id   = '0;
        m_ptr  = '0;
        m_pend = '0;
        m_ovf  = '0;
    endtask

    // hist[0] is the input sampled at the previous edge; an event is visible
    // NST-1 edges after first sampling and is latched one edge later.
    task automatic model_edge();
        logic [NREQ-1:0] rise, cons, old;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rise = hist[NST-1] & ~hist[NST];
        cons = '0;
        if (m_busy && ready) cons[m_id] = 1'b1;
        old    = m_pend;
        m_ovf  = (clr ? '0 : m_ovf) | (rise & old & ~cons);
        m_pend = (old & ~cons) | rise;
        if (m_busy) begin
            if (ready) begin
                m_busy = 1'b0;
                m_ptr  = IDW'((int'(m_id) + 1) % int'(NREQ));
            end
        end else if (old != '0) begin
            m_busy = 1'b1;
            m_id   = IDW'(rr_pick(old, int'(m_ptr)));
        end
        hist.push_front(req);
        void'(hist.pop_back());
    endtask

    task automatic check_model();
        check("valid", 32'(valid), 32'(m_busy));
        check("id", 32'(id), 32'(m_id));
        check("pending", 32'(pend), 32'(m_pend));
        check("overflow", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_model();
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        while (!valid && n < maxc) begin
            tick();
            n++;
        end
        check("wait_valid", 32'(valid), 32'd1);
    endtask

    task automatic quiet(input int n);
        req = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int got_ids [$];
        int nvalid;

        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
        clr   = 1'b0;
        model_reset();

        // Reset and basic grant
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_valid", 32'(valid), 32'd0);
            check("reset_pend", 32'(pend), 32'd0);
        end
        rst_n = 1'b1;
        tick();                                  // edge 4
        req   = 4'b0100;
        ready = 1'b1;
        tick();                                  // edge 5
        tick();                                  // edge 6
        tick();                                  // edge 7
        check("basic_pend_e7", 32'(pend), 32'h4);
        check("basic_valid_e7", 32'(valid), 32'd0);
        tick();                                  // edge 8
        check("basic_valid_e8", 32'(valid), 32'd1);
        check("basic_id_e8", 32'(id), 32'd2);
        tick();                                  // edge 9
        check("basic_valid_e9", 32'(valid), 32'd0);
        check("basic_pend_e9", 32'(pend), 32'd0);

        // Round-robin order from ptr=3
        quiet(4);
        req = 4'b1011;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid) got_ids.push_back(int'(id));
        end
        check("rr_count", 32'(got_ids.size()), 32'd3);
        if (got_ids.size() == 3) begin
            check("rr_first", 32'(got_ids[0]), 32'd3);
            check("rr_second", 32'(got_ids[1]), 32'd0);
            check("rr_third", 32'(got_ids[2]), 32'd1);
        end

        // Back-pressure
        ready = 1'b0;
        quiet(4);
        req = 4'b0010;
        wait_valid(10);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 32'(valid), 32'd1);
            check("bp_id", 32'(id), 32'd1);
        end
        ready = 1'b1;
        tick();
        check("bp_release", 32'(valid), 32'd0);

        // Overflow and clear
        ready = 1'b0;
        quiet(4);
        req = 4'b0001;
        wait_valid(10);
        check("ovf_id", 32'(id), 32'd0);
        req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        req = 4'b0001;
        for (int i = 0; i <= int'(NST); i++) tick();
        check("ovf_set", 32'(ovf), 32'h1);
        check("ovf_pend", 32'(pend), 32'h1);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovf_clr", 32'(ovf), 32'd0);
        ready = 1'b1;
        tick();
        check("ovf_release", 32'(valid), 32'd0);
        nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid) nvalid++;
        end
        check("ovf_single_grant", 32'(nvalid), 32'd0);

        // Simultaneous consume and re-arrival on bit 2
        ready = 1'b0;
        quiet(4);
        req = 4'b0100;
        wait_valid(10);
        check("sim_id", 32'(id), 32'd2);
        req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        req = 4'b0100;
        for (int i = 0; i < int'(NST); i++) tick();
        ready = 1'b1;
        tick();                                  // handshake edge coincides with latch
        check("sim_pend2", 32'(pend[2]), 32'd1);
        check("sim_ovf2", 32'(ovf[2]), 32'd0);
        check("sim_gap", 32'(valid), 32'd0);
        ready = 1'b0;
        tick();
        check("sim_regrant_valid", 32'(valid), 32'd1);
        check("sim_regrant_id", 32'(id), 32'd2);
        ready = 1'b1;
        tick();

        // Reset mid-grant
        ready = 1'b0;
        quiet(4);
        req = 4'b1000;
        wait_valid(10);
        check("rst_id", 32'(id), 32'd3);
        req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pend", 32'(pend), 32'd0);
        rst_n = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid) nvalid++;
        end
        check("rst_no_replay", 32'(nvalid), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            req   = req ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            ready = ($urandom % 3) != 0;
            clr   = ($urandom % 16) == 0;
            rst_n = ($urandom % 250) != 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
